// File: rtl/levmarq_mul_pipe.sv
// levmarq_mul_pipe: pipelined signed multiplier with valid/ready backpressure and post-product shift.
// Define LEVMARQ_MUL_SAT_EN to saturate dout on overflow instead of wrapping.
module levmarq_mul_pipe #(
  parameter int ID = 1,
  parameter int NUM_STAGE = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SHIFT = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam int EW = (DW > PW) ? DW : PW;

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || ID < 0) begin : g_bad_cfg
    $error("levmarq_mul_pipe: NUM_STAGE must be 1..8");
  end

  logic signed [PW-1:0] p, s;
  logic signed [EW-1:0] se;
  logic [EW-DW:0] hi;
  logic of, live, acc, chain;
  logic [DW-1:0] res;
  logic [NUM_STAGE-1:0] v, adv;

  assign p = PW'(din0) * PW'(din1);
  assign s = p >>> SHIFT;
  assign se = EW'(s);
  // everything above the dout sign bit must replicate it for the value to fit
  assign hi = se[EW-1:DW-1];
  assign of = !(&hi || !(|hi));
`ifdef LEVMARQ_MUL_SAT_EN
  assign res = !of ? se[DW-1:0] : se[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
  assign res = se[DW-1:0];
`endif

  // a full pipe only frees slot 0 when the tail drains, hence the single out_ready term
  assign in_ready = live && (!(&v) || out_ready);
  assign acc = in_valid && in_ready;

  always_comb begin
    chain = out_ready;
    adv = '0;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      adv[k] = v[k] && chain;
      chain = !v[k] || adv[k];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) live <= 1'b0;
    else live <= 1'b1;

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_slot
    logic vr, fin;
    logic [DW:0] dr, src;
    if (i == 0) begin : g_head
      assign fin = acc;
      assign src = {of, res};
    end else begin : g_tail
      assign fin = adv[i-1];
      assign src = g_slot[i-1].dr;
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
        vr <= 1'b0;
        dr <= '0;
      end else begin
        vr <= fin || (vr && !adv[i]);
        if (fin) dr <= src;
      end
    assign v[i] = vr;
  end

  assign out_valid = v[NUM_STAGE-1];
  assign dout = g_slot[NUM_STAGE-1].dr[DW-1:0];
  assign ovf = g_slot[NUM_STAGE-1].dr[DW];
endmodule

// File: tb/tb_levmarq_mul_pipe.sv
// tb_levmarq_mul_pipe: four differently configured pipes share one stimulus stream;
// each is scored against an arithmetic reference model.
module tb_levmarq_mul_pipe;
  localparam int NS[4]  = '{3, 1, 8, 2};
  localparam int W0[4]  = '{14, 14, 14, 6};
  localparam int W1[4]  = '{12, 12, 12, 5};
  localparam int DWS[4] = '{26, 8, 26, 16};
  localparam int SH[4]  = '{0, 0, 4, 0};

  logic ap_clk = 1'b0, ap_rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [13:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic [3:0] irdy, ov, ofx;
  logic signed [25:0] d0, d2;
  logic signed [7:0] d1;
  logic signed [15:0] d3;
  logic [31:0] dx [4];
  logic [32:0] sb [4][16];
  logic [32:0] pd [4];
  logic [32:0] cap [4];
  logic [3:0] pst = '0;
  int wp [4] = '{0, 0, 0, 0};
  int rp [4] = '{0, 0, 0, 0};
  int tests = 0, fails = 0;

  assign dx[0] = 32'(d0);
  assign dx[1] = 32'(d1);
  assign dx[2] = 32'(d2);
  assign dx[3] = 32'(d3);

  always #5 ap_clk = ~ap_clk;

  levmarq_mul_pipe #(.ID(0), .NUM_STAGE(NS[0]), .din0_WIDTH(W0[0]), .din1_WIDTH(W1[0]),
    .dout_WIDTH(DWS[0]), .SHIFT(SH[0])) u0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(irdy[0]), .din0(din0), .din1(din1),
    .out_valid(ov[0]), .out_ready(out_ready), .dout(d0), .ovf(ofx[0]));
  levmarq_mul_pipe #(.ID(1), .NUM_STAGE(NS[1]), .din0_WIDTH(W0[1]), .din1_WIDTH(W1[1]),
    .dout_WIDTH(DWS[1]), .SHIFT(SH[1])) u1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(irdy[1]), .din0(din0), .din1(din1),
    .out_valid(ov[1]), .out_ready(out_ready), .dout(d1), .ovf(ofx[1]));
  levmarq_mul_pipe #(.ID(2), .NUM_STAGE(NS[2]), .din0_WIDTH(W0[2]), .din1_WIDTH(W1[2]),
    .dout_WIDTH(DWS[2]), .SHIFT(SH[2])) u2 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(irdy[2]), .din0(din0), .din1(din1),
    .out_valid(ov[2]), .out_ready(out_ready), .dout(d2), .ovf(ofx[2]));
  levmarq_mul_pipe #(.ID(3), .NUM_STAGE(NS[3]), .din0_WIDTH(W0[3]), .din1_WIDTH(W1[3]),
    .dout_WIDTH(DWS[3]), .SHIFT(SH[3])) u3 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(irdy[3]), .din0(din0[5:0]), .din1(din1[4:0]),
    .out_valid(ov[3]), .out_ready(out_ready), .dout(d3), .ovf(ofx[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {ovf, dout sign-extended to 32} from plain integer arithmetic
  function automatic logic [32:0] model(input int k, input logic [13:0] a, input logic [11:0] b);
    longint x, y, s, lo, hi, w, m;
    logic o;
    x = longint'(a) <<< (64 - W0[k]);
    x = x >>> (64 - W0[k]);
    y = longint'(b) <<< (64 - W1[k]);
    y = y >>> (64 - W1[k]);
    s = (x * y) >>> SH[k];
    m = longint'(1) <<< DWS[k];
    lo = -(m / 2);
    hi = m / 2 - 1;
    o = (s < lo) || (s > hi);
    w = s & (m - 1);
    if (w > hi) w = w - m;
`ifdef LEVMARQ_MUL_SAT_EN
    if (o) w = (s < 0) ? lo : hi;
`endif
    return {o, w[31:0]};
  endfunction

  task automatic mon();
    for (int k = 0; k < 4; k++) begin
      if (pst[k]) chk($sformatf("hold%0d", k), {30'b0, ov[k], ofx[k], dx[k]}, {30'b0, 1'b1, pd[k]});
      if (in_valid && irdy[k]) begin
        sb[k][wp[k] % 16] = model(k, din0, din1);
        wp[k]++;
      end
      if (ov[k] && out_ready) begin
        if (wp[k] == rp[k]) chk($sformatf("spurious%0d", k), 64'(ov[k]), 64'd0);
        else begin
          chk($sformatf("sb%0d", k), {31'b0, ofx[k], dx[k]}, {31'b0, sb[k][rp[k] % 16]});
          rp[k]++;
        end
      end
      pst[k] = ov[k] && !out_ready;
      pd[k] = {ofx[k], dx[k]};
    end
  endtask

  task automatic step(input logic v, input logic [13:0] a, input logic [11:0] b, input logic r);
    in_valid = v;
    din0 = a;
    din1 = b;
    out_ready = r;
    @(negedge ap_clk);
    mon();
    @(posedge ap_clk);
    #1;
  endtask

  // one sample into empty pipes; checks latency, single-cycle out_valid and captures each result
  task automatic single(input logic [13:0] a, input logic [11:0] b);
    int first [4];
    int cnt [4];
    for (int k = 0; k < 4; k++) begin
      first[k] = -1;
      cnt[k] = 0;
    end
    repeat (10) step(1'b0, '0, '0, 1'b1);
    chk("idle_rdy", 64'(irdy), 64'hF);
    for (int j = 0; j <= 10; j++) begin
      in_valid = (j == 0);
      din0 = a;
      din1 = b;
      out_ready = 1'b1;
      @(negedge ap_clk);
      mon();
      for (int k = 0; k < 4; k++)
        if (ov[k]) begin
          if (first[k] < 0) begin
            first[k] = j;
            cap[k] = {ofx[k], dx[k]};
          end
          cnt[k]++;
        end
      @(posedge ap_clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lat%0d", k), 64'(first[k]), 64'(NS[k]));
      chk($sformatf("once%0d", k), 64'(cnt[k]), 64'd1);
    end
  endtask

  initial begin
    int acc, npop;
    int popc [10];
    logic [31:0] popv [10];
    logic [13:0] idx;
    logic [32:0] e;
    #12;
    chk("rst_ov", 64'(ov), 64'd0);
    chk("rst_rdy", 64'(irdy), 64'd0);
    chk("rst_d01", {dx[0], dx[1]}, 64'd0);
    chk("rst_d23", {dx[2], dx[3]}, 64'd0);
    chk("rst_ovf", 64'(ofx), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_rdy0", 64'(irdy), 64'd0);
    @(posedge ap_clk);
    #1;
    chk("rel_rdy1", 64'(irdy), 64'hF);

    single(14'h2000, 12'h800);
    chk("full_prod", 64'(cap[0]), 64'({1'b0, 32'd16777216}));
    single(14'd100, 12'd3);
`ifdef LEVMARQ_MUL_SAT_EN
    e = {1'b1, 32'd127};
`else
    e = {1'b1, 32'd44};
`endif
    chk("dw8_pos", 64'(cap[1]), 64'(e));
    single(14'(-100), 12'd3);
`ifdef LEVMARQ_MUL_SAT_EN
    e = {1'b1, 32'hFFFF_FF80};
`else
    e = {1'b1, 32'hFFFF_FFD4};
`endif
    chk("dw8_neg", 64'(cap[1]), 64'(e));
    single(14'(-37), 12'd5);
    chk("shift4", 64'(cap[2]), 64'({1'b0, 32'hFFFF_FFF4}));
    chk("noshift", 64'(cap[0]), 64'({1'b0, 32'hFFFF_FF47}));

    repeat (10) step(1'b0, '0, '0, 1'b1);
    idx = 14'd1;
    acc = 0;
    npop = 0;
    for (int c = 0; c < 40 && npop < 10; c++) begin
      in_valid = (idx <= 14'd10);
      din0 = idx;
      din1 = 12'd1;
      out_ready = (c >= 6);
      @(negedge ap_clk);
      if (c < 6) chk($sformatf("bp_rdy%0d", c), 64'(irdy[0]), 64'(acc < 3));
      if (c >= 3 && c < 6) chk("bp_hold", {31'b0, ov[0], dx[0]}, {31'b0, 1'b1, 32'd1});
      if (ov[0] && out_ready) begin
        popv[npop] = dx[0];
        popc[npop] = c;
        npop++;
      end
      if (in_valid && irdy[0]) acc++;
      mon();
      @(posedge ap_clk);
      #1;
      idx = 14'(acc + 1);
    end
    chk("bp_count", 64'(npop), 64'd10);
    for (int i = 0; i < npop; i++) begin
      chk($sformatf("bp_val%0d", i), 64'(popv[i]), 64'(i + 1));
      chk($sformatf("bp_cyc%0d", i), 64'(popc[i]), 64'(6 + i));
    end

    for (int c = 0; c < 24000; c++) begin
      din0 = 14'($urandom);
      if ($urandom_range(0, 7) == 0) din0 = 14'h2000;
      step(1'($urandom), din0, 12'($urandom), 1'($urandom));
    end

    repeat (10) step(1'b0, '0, '0, 1'b1);
    step(1'b1, 14'd7, 12'd9, 1'b0);
    step(1'b1, 14'd5, 12'd3, 1'b0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mid_ov", 64'(ov), 64'd0);
    chk("mid_rdy", 64'(irdy), 64'd0);
    chk("mid_d01", {dx[0], dx[1]}, 64'd0);
    chk("mid_d23", {dx[2], dx[3]}, 64'd0);
    chk("mid_ovf", 64'(ofx), 64'd0);
    for (int k = 0; k < 4; k++) rp[k] = wp[k];
    pst = '0;
    in_valid = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("mid_rel_rdy", 64'(irdy), 64'hF);
    repeat (12) step(1'b0, '0, '0, 1'b1);
    single(14'd3, 12'd4);
    chk("post_rst", 64'(cap[0]), 64'({1'b0, 32'd12}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
